// File: rtl/seg7_reader_pkg.sv
// Shared constants for the 7-segment reader: hex glyphs (a..g MSB first),
// segment bit positions and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h7E;
  localparam logic [6:0] GLYPH_1 = 7'h30;
  localparam logic [6:0] GLYPH_2 = 7'h6D;
  localparam logic [6:0] GLYPH_3 = 7'h79;
  localparam logic [6:0] GLYPH_4 = 7'h33;
  localparam logic [6:0] GLYPH_5 = 7'h5B;
  localparam logic [6:0] GLYPH_6 = 7'h5F;
  localparam logic [6:0] GLYPH_7 = 7'h70;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h7B;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h1F;
  localparam logic [6:0] GLYPH_C = 7'h4E;
  localparam logic [6:0] GLYPH_D = 7'h3D;
  localparam logic [6:0] GLYPH_E = 7'h4F;
  localparam logic [6:0] GLYPH_F = 7'h47;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } seg7_state_e;

  // Common-anode buses drive a lit segment as 0; normalise to active-high.
  function automatic logic [6:0] seg7_normalise(input logic [6:0] seg,
                                                input logic      active_low);
    return seg ^ {7{active_low}};
  endfunction

endpackage

// File: rtl/seg7_reader_glyph_match.sv
// Combinational glyph decoder: a..g pattern to {hit, hex nibble}.
module seg7_glyph_match
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       hit_o,
  output logic [3:0] nibble_o
);

  // Reverse lookup of the hex glyph table; anything else is a miss.
  always_comb begin
    hit_o    = 1'b1;
    nibble_o = 4'h0;
    case (pattern_i)
      GLYPH_0: nibble_o = 4'h0;
      GLYPH_1: nibble_o = 4'h1;
      GLYPH_2: nibble_o = 4'h2;
      GLYPH_3: nibble_o = 4'h3;
      GLYPH_4: nibble_o = 4'h4;
      GLYPH_5: nibble_o = 4'h5;
      GLYPH_6: nibble_o = 4'h6;
      GLYPH_7: nibble_o = 4'h7;
      GLYPH_8: nibble_o = 4'h8;
      GLYPH_9: nibble_o = 4'h9;
      GLYPH_A: nibble_o = 4'hA;
      GLYPH_B: nibble_o = 4'hB;
      GLYPH_C: nibble_o = 4'hC;
      GLYPH_D: nibble_o = 4'hD;
      GLYPH_E: nibble_o = 4'hE;
      GLYPH_F: nibble_o = 4'hF;
      default: begin
        hit_o    = 1'b0;
        nibble_o = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Segment-bus reader: debounces a..g patterns, decodes hex digits and packs
// DIGITS of them into a word on a valid/ready port. SEG7_READER_ACTIVE_LOW_EN
// selects a common-anode (active-low) segment bus.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic                  seg_valid,
  output logic [4*DIGITS-1:0]   out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  bad_pattern,
  output logic                  overrun
);

  localparam int W = 4 * DIGITS;
  localparam logic [7:0] STABLE_N   = 8'(STABLE_CYCLES);
  localparam logic [3:0] DIGITS_N   = 4'(DIGITS);
  localparam logic       STABLE_ONE = (STABLE_CYCLES == 1);

`ifdef SEG7_READER_ACTIVE_LOW_EN
  localparam logic ACTIVE_LOW = 1'b1;
`else
  localparam logic ACTIVE_LOW = 1'b0;
`endif

  seg7_state_e   state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [6:0]    prev_q, prev_d;
  logic [W-1:0]  word_q, word_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic          valid_q, valid_d;
  logic          bad_q, bad_d;
  logic          ovr_q, ovr_d;

  logic [6:0]    seg_s;
  logic [7:0]    cnt_inc_s;
  logic          eval_s;
  logic          hit_s;
  logic [3:0]    nibble_s;
  logic          hs_s;
  logic [3:0]    dcnt_base_s;
  logic [W+3:0]  shifted_s;

  assign seg_s     = seg7_normalise(seg_in, ACTIVE_LOW);
  assign cnt_inc_s = cnt_q + 8'd1;
  assign hs_s      = valid_q & out_ready;

  seg7_glyph_match u_match (
    .pattern_i (seg_s),
    .hit_o     (hit_s),
    .nibble_o  (nibble_s)
  );

  // Stability FSM: one evaluation per seg_valid high period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    eval_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (seg_valid) begin
          prev_d  = seg_s;
          cnt_d   = 8'd1;
          eval_s  = STABLE_ONE;
          state_d = STABLE_ONE ? LOCKED : SETTLE;
        end else begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (!seg_valid) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (seg_s == prev_q) begin
          cnt_d   = cnt_inc_s;
          eval_s  = (cnt_inc_s == STABLE_N);
          state_d = eval_s ? LOCKED : SETTLE;
        end else begin
          prev_d  = seg_s;
          cnt_d   = 8'd1;
          state_d = SETTLE;
        end
      end
      LOCKED: begin
        if (!seg_valid) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Word assembly, handshake and status flags.
  always_comb begin
    word_d      = word_q;
    dcnt_d      = dcnt_q;
    valid_d     = valid_q;
    ovr_d       = ovr_q;
    bad_d       = 1'b0;
    shifted_s   = {word_q, nibble_s};
    dcnt_base_s = hs_s ? 4'd0 : dcnt_q;
    if (hs_s) begin
      valid_d = 1'b0;
      dcnt_d  = 4'd0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (eval_s) begin
      if (!hit_s) begin
        bad_d = 1'b1;
      end else if (!valid_q || hs_s) begin
        // A digit landing on the handshake edge starts the next word.
        word_d  = shifted_s[W-1:0];
        dcnt_d  = dcnt_base_s + 4'd1;
        valid_d = (dcnt_base_s + 4'd1 == DIGITS_N);
      end else begin
        ovr_d = 1'b1;
      end
    end else begin
      bad_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      prev_q  <= 7'd0;
      word_q  <= '0;
      dcnt_q  <= 4'd0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      word_q  <= word_d;
      dcnt_q  <= dcnt_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_word    = word_q;
  assign out_valid   = valid_q;
  assign bad_pattern = bad_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Randomised self-checking bench for seg7_reader against a digit-level model.
module tb_seg7_reader;

  localparam int S = 4;
  localparam int D = 4;

`ifdef SEG7_READER_ACTIVE_LOW_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        bad_pattern;
  logic        overrun;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(S), .DIGITS(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .seg_valid   (seg_valid),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .bad_pattern (bad_pattern),
    .overrun     (overrun)
  );

  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_word;
  int          m_cnt;
  bit          m_valid, m_ov;
  int          exp_bad, bad_seen;
  logic [15:0] exp_q[$];
  logic [15:0] rx_q[$];
  logic [6:0]  run_pat[$];
  int          run_len[$];
  int          step_no, valid_cycles, last_valid_step, first_high_step;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (glyph_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_word = 16'h0; m_cnt = 0; m_valid = 1'b0; m_ov = 1'b0;
    exp_bad = 0; bad_seen = 0;
    exp_q.delete(); rx_q.delete();
  endtask

  // One accepted pattern at word level.
  task automatic model_eval(input logic [6:0] p);
    int n;
    n = ref_lookup(p);
    if (n < 0) exp_bad++;
    else if (m_valid) m_ov = 1'b1;
    else begin
      m_word = {m_word[11:0], 4'(n)};
      m_cnt++;
      if (m_cnt == D) begin
        m_cnt = 0;
        if (out_ready) exp_q.push_back(m_word);
        else m_valid = 1'b1;
      end
    end
  endtask

  // One clock: drive at negedge, capture handshake before the edge, observe after.
  task automatic step(input logic [6:0] p, input logic v);
    seg_in    = ACT_LOW ? ~p : p;
    seg_valid = v;
    #1;
    if (out_valid && out_ready) rx_q.push_back(out_word);
    @(posedge clk);
    step_no++;
    @(negedge clk);
    if (bad_pattern) bad_seen++;
    if (out_valid) begin
      valid_cycles++;
      last_valid_step = step_no;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "/word"}, 32'(out_word), 32'(m_word));
    check_eq({tag, "/valid"}, 32'(out_valid), 32'(m_valid));
    check_eq({tag, "/overrun"}, 32'(overrun), 32'(m_ov));
    check_eq({tag, "/bad"}, 32'(bad_seen), 32'(exp_bad));
    check_eq({tag, "/nwords"}, 32'(rx_q.size()), 32'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "/rxword"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    rx_q.delete(); exp_q.delete();
  endtask

  // One seg_valid high period built from run_pat/run_len, then a low gap.
  task automatic period(input int gap);
    int acc;
    acc = -1;
    if (out_ready && m_valid) begin
      exp_q.push_back(m_word);
      m_valid = 1'b0;
      m_ov    = 1'b0;
    end
    for (int i = 0; i < run_pat.size(); i++)
      if (acc < 0 && run_len[i] >= S) acc = i;
    if (acc >= 0) model_eval(run_pat[acc]);
    first_high_step = step_no + 1;
    for (int i = 0; i < run_pat.size(); i++)
      for (int j = 0; j < run_len[i]; j++) step(run_pat[i], 1'b1);
    for (int i = 0; i < gap; i++) step(7'($urandom), 1'b0);
    run_pat.delete(); run_len.delete();
  endtask

  task automatic digit(input logic [6:0] p);
    run_pat.push_back(p); run_len.push_back(S);
    period(1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check_eq({tag, "/word"}, 32'(out_word), 32'h0);
    check_eq({tag, "/valid"}, 32'(out_valid), 32'h0);
    check_eq({tag, "/overrun"}, 32'(overrun), 32'h0);
    check_eq({tag, "/bad"}, 32'(bad_pattern), 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] mp, gp;
    int kind;
    rst_n = 1'b0; seg_in = 7'h0; seg_valid = 1'b0; out_ready = 1'b1;
    step_no = 0; valid_cycles = 0; last_valid_step = 0; first_high_step = 0;
    model_clear();
    @(negedge clk); @(negedge clk);
    do_reset("reset");

    // Basic word 1234 with latency and single-cycle valid.
    valid_cycles = 0;
    digit(7'h30); digit(7'h6D); digit(7'h79); digit(7'h33);
    check_eq("s1/latency", 32'(last_valid_step - first_high_step), 32'(S - 1));
    check_eq("s1/pulse", 32'(valid_cycles), 32'd1);
    check_eq("s1/word1234", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'h1234);
    check_state("s1");

    // Glitch then stable 8, then complete the word.
    run_pat.push_back(7'h7E); run_len.push_back(2);
    run_pat.push_back(7'h7F); run_len.push_back(4);
    period(1);
    check_eq("s2/word8", 32'(out_word[3:0]), 32'h8);
    check_state("s2a");
    digit(7'h7B); digit(7'h77); digit(7'h1F);
    check_state("s2b");

    // Bad pattern leaves the word untouched.
    digit(7'h00);
    check_eq("s3/badpulse", 32'(bad_seen), 32'd1);
    check_state("s3a");
    digit(7'h4E); digit(7'h3D); digit(7'h4F); digit(7'h47);
    check_eq("s3/wordCDEF", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'hCDEF);
    check_state("s3b");

    // Overrun while the word is held.
    out_ready = 1'b0;
    digit(7'h77); digit(7'h1F); digit(7'h4E); digit(7'h3D);
    check_state("s4a");
    digit(7'h30);
    check_eq("s4/overrun", 32'(overrun), 32'd1);
    check_eq("s4/holdABCD", 32'(out_word), 32'hABCD);
    check_state("s4b");
    out_ready = 1'b1;
    if (m_valid) begin exp_q.push_back(m_word); m_valid = 1'b0; m_ov = 1'b0; end
    step(7'h00, 1'b0);
    check_eq("s4/cleared", 32'({out_valid, overrun}), 32'd0);
    check_state("s4c");

    // Reset mid-word discards the partial word.
    digit(7'h5B); digit(7'h5F);
    do_reset("s5rst");
    digit(7'h5B); digit(7'h5F); digit(7'h70); digit(7'h7F);
    check_eq("s5/word5678", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'h5678);
    check_state("s5");

    // Randomised periods against the model.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      mp = (kind < 7) ? glyph_tab[$urandom_range(0, 15)] : 7'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        gp = 7'($urandom);
        if (gp == mp) gp = ~mp;
        run_pat.push_back(gp); run_len.push_back($urandom_range(1, S - 1));
      end
      run_pat.push_back(mp);
      run_len.push_back((kind == 9) ? $urandom_range(1, S - 1) : $urandom_range(S, S + 2));
      out_ready = ($urandom_range(0, 3) != 0);
      period($urandom_range(1, 2));
      check_state("rand");
    end

    out_ready = 1'b1;
    if (m_valid) begin exp_q.push_back(m_word); m_valid = 1'b0; m_ov = 1'b0; end
    step(7'h00, 1'b0); step(7'h00, 1'b0);
    check_state("drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
